// File: rtl/comp_mon_pkg.sv
// Shared definitions for the comparator result monitor: run-state codes and
// the one-hot validity helper for the {y_gt, y_eq, y_lt} flag vector.
package comp_mon_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
  localparam logic [ST_W-1:0] ST_GT   = 2'b01;
  localparam logic [ST_W-1:0] ST_EQ   = 2'b10;
  localparam logic [ST_W-1:0] ST_LT   = 2'b11;

  function automatic logic onehot3(input logic [2:0] flags);
    return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  endfunction

endpackage

// File: rtl/comp_result_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and soft clear; holds at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/comp_result_monitor.sv
// Comparator result monitor: outcome tallies, run tracking with streak alarm and
// sticky one-hot error. Define COMP_MON_HIST_EN to add the 4-deep outcome history port.
module comp_result_monitor
  import comp_mon_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int RUN_W     = 8,
  parameter int STREAK_TH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             y_gt,
  input  logic             y_eq,
  input  logic             y_lt,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [1:0]       run_state,
  output logic [RUN_W-1:0] run_len,
  output logic             alarm,
  output logic             err_onehot
`ifdef COMP_MON_HIST_EN
  ,
  output logic [7:0]       hist
`endif
);

  localparam logic [RUN_W-1:0] RunMax   = '1;
  localparam logic [RUN_W-1:0] ThMinus1 = RUN_W'(STREAK_TH - 1);

  logic [2:0]      flags;
  logic            sampleGood;
  logic            sampleBad;
  logic [ST_W-1:0] sampleCode;

  logic [ST_W-1:0]  state_q, state_d;
  logic [RUN_W-1:0] runLen_q, runLen_d;
  logic             alarm_q, alarm_d;
  logic             err_q, err_d;

  assign flags      = {y_gt, y_eq, y_lt};
  assign sampleGood = in_valid && onehot3(flags);
  assign sampleBad  = in_valid && !onehot3(flags);

  always_comb begin
    sampleCode = ST_IDLE;
    if (y_gt)
      sampleCode = ST_GT;
    else if (y_eq)
      sampleCode = ST_EQ;
    else if (y_lt)
      sampleCode = ST_LT;
  end

  sat_counter #(.W(CNT_W)) u_cnt_gt (
    .clk(clk), .rst(rst), .clr(clear), .inc(sampleGood && y_gt), .q(cnt_gt)
  );
  sat_counter #(.W(CNT_W)) u_cnt_eq (
    .clk(clk), .rst(rst), .clr(clear), .inc(sampleGood && y_eq), .q(cnt_eq)
  );
  sat_counter #(.W(CNT_W)) u_cnt_lt (
    .clk(clk), .rst(rst), .clr(clear), .inc(sampleGood && y_lt), .q(cnt_lt)
  );

  // A new run fires the alarm only when the threshold is 1; a continuing run fires
  // it only on the step into the threshold, so saturation never re-triggers it.
  always_comb begin
    state_d  = state_q;
    runLen_d = runLen_q;
    alarm_d  = 1'b0;
    err_d    = err_q;
    if (clear) begin
      state_d  = ST_IDLE;
      runLen_d = '0;
      err_d    = 1'b0;
    end else if (sampleBad) begin
      state_d  = ST_IDLE;
      runLen_d = '0;
      err_d    = 1'b1;
    end else if (sampleGood) begin
      state_d = sampleCode;
      if (state_q == sampleCode) begin
        if (runLen_q != RunMax)
          runLen_d = runLen_q + RUN_W'(1);
        alarm_d = (runLen_q == ThMinus1);
      end else begin
        runLen_d = RUN_W'(1);
        alarm_d  = (STREAK_TH == 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      runLen_q <= '0;
      alarm_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      runLen_q <= runLen_d;
      alarm_q  <= alarm_d;
      err_q    <= err_d;
    end
  end

  assign run_state  = state_q;
  assign run_len    = runLen_q;
  assign alarm      = alarm_q;
  assign err_onehot = err_q;

`ifdef COMP_MON_HIST_EN
  logic [7:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (clear)
      hist_d = '0;
    else if (sampleGood)
      hist_d = {hist_q[5:0], sampleCode};
  end

  always_ff @(posedge clk) begin
    if (rst)
      hist_q <= '0;
    else
      hist_q <= hist_d;
  end

  assign hist = hist_q;
`endif

endmodule

// File: tb/tb_comp_result_monitor.sv
// Self-checking bench for comp_result_monitor: a directed vector table, saturation and
// history sequences, then randomized traffic against an unbounded-count reference model.
module tb_comp_result_monitor;

  localparam int S_CNT_W = 2;
  localparam int S_RUN_W = 2;
  localparam int S_TH    = 3;
  localparam int B_TH    = 4;

  logic clk = 1'b0;
  logic rst, clear, inValid, yGt, yEq, yLt;

  logic [15:0] bigGt, bigEq, bigLt;
  logic [1:0]  bigState;
  logic [7:0]  bigLen;
  logic        bigAlarm, bigErr;

  logic [S_CNT_W-1:0] smlGt, smlEq, smlLt;
  logic [1:0]         smlState;
  logic [S_RUN_W-1:0] smlLen;
  logic               smlAlarm, smlErr;

`ifdef COMP_MON_HIST_EN
  logic [7:0] bigHist, smlHist;
`endif

  always #5 clk = ~clk;

  comp_result_monitor dutBig (
    .clk(clk), .rst(rst), .in_valid(inValid), .y_gt(yGt), .y_eq(yEq), .y_lt(yLt),
    .clear(clear), .cnt_gt(bigGt), .cnt_eq(bigEq), .cnt_lt(bigLt),
    .run_state(bigState), .run_len(bigLen), .alarm(bigAlarm), .err_onehot(bigErr)
`ifdef COMP_MON_HIST_EN
    , .hist(bigHist)
`endif
  );

  comp_result_monitor #(.CNT_W(S_CNT_W), .RUN_W(S_RUN_W), .STREAK_TH(S_TH)) dutSmall (
    .clk(clk), .rst(rst), .in_valid(inValid), .y_gt(yGt), .y_eq(yEq), .y_lt(yLt),
    .clear(clear), .cnt_gt(smlGt), .cnt_eq(smlEq), .cnt_lt(smlLt),
    .run_state(smlState), .run_len(smlLen), .alarm(smlAlarm), .err_onehot(smlErr)
`ifdef COMP_MON_HIST_EN
    , .hist(smlHist)
`endif
  );

  int checkCount = 0;
  int failCount  = 0;

  // Reference model: unbounded tallies and run length, clipped to each instance's width on compare.
  int         mCnt[3];
  int         mRun;
  int         mState;
  bit         mAlarmBig, mAlarmSml, mErr;
  logic [7:0] mHist;

  typedef struct {
    logic       rstV;
    logic       clrV;
    logic       vld;
    logic [2:0] f;
    int         gt;
    int         eq;
    int         lt;
    int         st;
    int         len;
    int         al;
    int         err;
  } vec_t;

  vec_t vecs[$];

  function automatic int clip(input int v, input int maxV);
    return (v > maxV) ? maxV : v;
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    checkCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelUpdate(input logic r, input logic c, input logic v, input logic [2:0] f);
    int code;
    mAlarmBig = 1'b0;
    mAlarmSml = 1'b0;
    if (r || c) begin
      mCnt = '{0, 0, 0};
      mRun = 0;
      mState = 0;
      mErr = 1'b0;
      mHist = 8'h00;
    end else if (v) begin
      if ($countones(f) == 1) begin
        code = f[2] ? 1 : (f[1] ? 2 : 3);
        mCnt[code-1]++;
        mRun = (mState == code) ? mRun + 1 : 1;
        mState = code;
        mAlarmBig = (mRun == B_TH);
        mAlarmSml = (mRun == S_TH);
        mHist = {mHist[5:0], 2'(code)};
      end else begin
        mRun = 0;
        mState = 0;
        mErr = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".big.cnt_gt"}, int'(bigGt), clip(mCnt[0], 65535));
    checkVal({tag, ".big.cnt_eq"}, int'(bigEq), clip(mCnt[1], 65535));
    checkVal({tag, ".big.cnt_lt"}, int'(bigLt), clip(mCnt[2], 65535));
    checkVal({tag, ".big.run_state"}, int'(bigState), mState);
    checkVal({tag, ".big.run_len"}, int'(bigLen), clip(mRun, 255));
    checkVal({tag, ".big.alarm"}, int'(bigAlarm), int'(mAlarmBig));
    checkVal({tag, ".big.err"}, int'(bigErr), int'(mErr));
    checkVal({tag, ".sml.cnt_gt"}, int'(smlGt), clip(mCnt[0], 3));
    checkVal({tag, ".sml.cnt_eq"}, int'(smlEq), clip(mCnt[1], 3));
    checkVal({tag, ".sml.cnt_lt"}, int'(smlLt), clip(mCnt[2], 3));
    checkVal({tag, ".sml.run_state"}, int'(smlState), mState);
    checkVal({tag, ".sml.run_len"}, int'(smlLen), clip(mRun, 3));
    checkVal({tag, ".sml.alarm"}, int'(smlAlarm), int'(mAlarmSml));
    checkVal({tag, ".sml.err"}, int'(smlErr), int'(mErr));
`ifdef COMP_MON_HIST_EN
    checkVal({tag, ".big.hist"}, int'(bigHist), int'(mHist));
    checkVal({tag, ".sml.hist"}, int'(smlHist), int'(mHist));
`endif
  endtask

  // Drives one cycle of inputs, steps the model at the edge and samples 1ns later.
  task automatic applyStimulus(input logic r, input logic c, input logic v, input logic [2:0] f,
                               input string tag);
    rst = r;
    clear = c;
    inValid = v;
    {yGt, yEq, yLt} = f;
    @(posedge clk);
    modelUpdate(r, c, v, f);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [2:0] lastF;
    logic [2:0] f;
    logic [2:0] ohTab[3];
    int pick;

    rst = 1'b1; clear = 1'b0; inValid = 1'b0; {yGt, yEq, yLt} = 3'b000;
    mCnt = '{0, 0, 0}; mRun = 0; mState = 0; mErr = 1'b0; mHist = 8'h00;
    mAlarmBig = 1'b0; mAlarmSml = 1'b0;
    ohTab[0] = 3'b100; ohTab[1] = 3'b010; ohTab[2] = 3'b001;

    //                rst  clr  vld  flags    gt eq lt st len al err
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b100, 1, 0, 0, 1, 1, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b100, 2, 0, 0, 1, 2, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b100, 3, 0, 0, 1, 3, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b100, 4, 0, 0, 1, 4, 1, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b100, 5, 0, 0, 1, 5, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b100, 1, 0, 0, 1, 1, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b010, 1, 1, 0, 2, 1, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b001, 1, 1, 1, 3, 1, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b001, 1, 1, 2, 3, 2, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b100, 1, 0, 0, 1, 1, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b100, 2, 0, 0, 1, 2, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b100, 3, 0, 0, 1, 3, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b110, 3, 0, 0, 0, 0, 0, 1});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b010, 3, 1, 0, 2, 1, 0, 1});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 3'b111, 3, 1, 0, 2, 1, 0, 1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b100, 1, 0, 0, 1, 1, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 3'b100, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b100, 1, 0, 0, 1, 1, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b100, 2, 0, 0, 1, 2, 0, 0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 1'b1, 3'b100, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 3'b000, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0, 0});

    $display("[TB] directed vector table, %0d rows", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstV, vecs[i].clrV, vecs[i].vld, vecs[i].f, $sformatf("vec%0d", i));
      checkVal($sformatf("tbl%0d.cnt_gt", i), int'(bigGt), vecs[i].gt);
      checkVal($sformatf("tbl%0d.cnt_eq", i), int'(bigEq), vecs[i].eq);
      checkVal($sformatf("tbl%0d.cnt_lt", i), int'(bigLt), vecs[i].lt);
      checkVal($sformatf("tbl%0d.run_state", i), int'(bigState), vecs[i].st);
      checkVal($sformatf("tbl%0d.run_len", i), int'(bigLen), vecs[i].len);
      checkVal($sformatf("tbl%0d.alarm", i), int'(bigAlarm), vecs[i].al);
      checkVal($sformatf("tbl%0d.err", i), int'(bigErr), vecs[i].err);
    end

    $display("[TB] saturation sequence on narrow instance");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 3'b001, $sformatf("sat%0d", i));
    checkVal("sat.sml.cnt_lt", int'(smlLt), 3);
    checkVal("sat.sml.run_len", int'(smlLen), 3);
    checkVal("sat.big.cnt_lt", int'(bigLt), 5);
    checkVal("sat.big.run_len", int'(bigLen), 5);

    $display("[TB] history sequence");
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, "hclr");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b100, "h0");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, "h1");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b001, "h2");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b011, "hbad");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b001, "h3");
`ifdef COMP_MON_HIST_EN
    checkVal("hist.big", int'(bigHist), int'(8'b01_10_11_11));
    checkVal("hist.sml", int'(smlHist), int'(8'b01_10_11_11));
`endif
    checkVal("hist.run_len", int'(bigLen), 1);
    checkVal("hist.err", int'(bigErr), 1);

    $display("[TB] randomized traffic");
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, "rclr");
    lastF = 3'b100;
    for (int i = 0; i < 3000; i++) begin
      pick = int'($urandom_range(0, 15));
      if (pick < 8)
        f = lastF;
      else if (pick < 14)
        f = ohTab[pick % 3];
      else
        f = 3'($urandom_range(0, 7));
      if ($countones(f) == 1)
        lastF = f;
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 79) == 0),
                    ($urandom_range(0, 3) != 0), f, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
